// File: rtl/trs80_cmd_pkg.sv
// Shared definitions for the TRS-80 /CMD file path (loader and saver).
//   CMD_LOAD / CMD_XFER : record type bytes
//   FSIZE_W             : width of the total-file-size counter
//   cmd_state_t         : saver FSM states
package trs80_cmd_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_XFER = 8'h02;
    localparam int         FSIZE_W  = 24;

    typedef enum logic [3:0] {
        IDLE,
        ARMED,
        HDR_TYPE,
        HDR_LEN,
        HDR_ALO,
        HDR_AHI,
        DATA,
        FETCH,
        XFR_TYPE,
        XFR_LEN,
        XFR_LO,
        XFR_HI
    } cmd_state_t;

endpackage

// File: rtl/cmd_saver.sv
// cmd_saver: serialises a RAM range into a TRS-80 /CMD byte stream on demand.
// The stream is a series of load records followed by one transfer record.
//
// Ports:
//   clock, reset_n              system clock, async active-low reset
//   save_req                    pulse: latch start/end/exec and arm a save
//   start_addr/end_addr         inclusive RAM range to save
//   exec_addr                   entry address for the transfer record
//   file_size                   total byte count of the file (valid while busy)
//   busy / done / err           armed-or-running / final byte out / bad range
//   upload                      host upload window; its falling edge aborts
//   rd_req, rd_data, rd_wait    host byte-request handshake
//   mem_rd, mem_addr, mem_data  dedicated RAM read port (MEM_LAT cycles)
module cmd_saver
    import trs80_cmd_pkg::*;
#(
    parameter int MEM_LAT  = 2,
    parameter int BLK_LOG2 = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               save_req,
    input  logic [15:0]        start_addr,
    input  logic [15:0]        end_addr,
    input  logic [15:0]        exec_addr,
    output logic [FSIZE_W-1:0] file_size,
    output logic               busy,
    output logic               done,
    output logic               err,
    input  logic               upload,
    input  logic               rd_req,
    output logic [7:0]         rd_data,
    output logic               rd_wait,
    output logic               mem_rd,
    output logic [15:0]        mem_addr,
    input  logic [7:0]         mem_data
);

    localparam int          BLK_SIZE   = 1 << BLK_LOG2;
    localparam logic [16:0] BLK_SIZE17 = 17'(BLK_SIZE);

    cmd_state_t  state, state_nxt;
    logic [15:0] ptr;        // next RAM byte to fetch
    logic [15:0] exec_q;
    logic [16:0] remaining;  // data bytes still to emit in the whole file
    logic [8:0]  blk_left;   // data bytes still to emit in the current record
    logic [2:0]  lat_cnt;
    logic        upload_q;

    // Range arithmetic on the live inputs, consumed only when a save is armed.
    logic              range_ok;
    logic [16:0]       n_bytes;
    logic [16:0]       n_blocks;
    logic [FSIZE_W-1:0] size_calc;

    assign range_ok  = (end_addr >= start_addr);
    assign n_bytes   = {1'b0, end_addr} - {1'b0, start_addr} + 17'd1;
    assign n_blocks  = (n_bytes + 17'(BLK_SIZE - 1)) >> BLK_LOG2;
    assign size_calc = FSIZE_W'(n_bytes) + FSIZE_W'({n_blocks, 2'b00}) + FSIZE_W'(4);

    // Host abort: falling edge of the upload window while a save is live.
    logic abort;
    logic fetch_done;
    assign abort      = busy && upload_q && !upload;
    assign fetch_done = (state == FETCH) && (lat_cnt == 3'(MEM_LAT));

    // Control decoded from the state. Each state names the byte the next
    // rd_req will deliver; ARMED behaves like HDR_TYPE but needs upload=1.
    logic       load_byte, start_fetch, capture, load_rec, finish, arm, reject;
    logic [7:0] byte_nxt;

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned, which would infer a latch.
    always_comb begin
        state_nxt   = state;
        load_byte   = 1'b0;
        byte_nxt    = 8'h00;
        start_fetch = 1'b0;
        capture     = 1'b0;
        load_rec    = 1'b0;
        finish      = 1'b0;
        arm         = 1'b0;
        reject      = 1'b0;

        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (save_req) begin
                        if (range_ok) begin
                            arm       = 1'b1;
                            state_nxt = ARMED;
                        end else begin
                            reject = 1'b1;
                        end
                    end
                    if (rd_req) load_byte = 1'b1;  // idle reads return 0x00
                end
                ARMED, HDR_TYPE: begin
                    if (rd_req && (upload || state == HDR_TYPE)) begin
                        load_byte = 1'b1;
                        byte_nxt  = CMD_LOAD;
                        load_rec  = 1'b1;
                        state_nxt = HDR_LEN;
                    end
                end
                HDR_LEN: if (rd_req) begin
                    load_byte = 1'b1;
                    byte_nxt  = blk_left[7:0] + 8'd2;  // LEN wraps mod 256
                    state_nxt = HDR_ALO;
                end
                HDR_ALO: if (rd_req) begin
                    load_byte = 1'b1;
                    byte_nxt  = ptr[7:0];
                    state_nxt = HDR_AHI;
                end
                HDR_AHI: if (rd_req) begin
                    load_byte = 1'b1;
                    byte_nxt  = ptr[15:8];
                    state_nxt = DATA;
                end
                DATA: if (rd_req) begin
                    start_fetch = 1'b1;
                    state_nxt   = FETCH;
                end
                FETCH: if (fetch_done) begin
                    capture   = 1'b1;
                    load_byte = 1'b1;
                    byte_nxt  = mem_data;
                    if (blk_left == 9'd1)
                        state_nxt = (remaining == 17'd1) ? XFR_TYPE : HDR_TYPE;
                    else
                        state_nxt = DATA;
                end
                XFR_TYPE: if (rd_req) begin
                    load_byte = 1'b1;
                    byte_nxt  = CMD_XFER;
                    state_nxt = XFR_LEN;
                end
                XFR_LEN: if (rd_req) begin
                    load_byte = 1'b1;
                    byte_nxt  = 8'h02;
                    state_nxt = XFR_LO;
                end
                XFR_LO: if (rd_req) begin
                    load_byte = 1'b1;
                    byte_nxt  = exec_q[7:0];
                    state_nxt = XFR_HI;
                end
                XFR_HI: if (rd_req) begin
                    load_byte = 1'b1;
                    byte_nxt  = exec_q[15:8];
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            file_size <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rd_data   <= 8'h00;
            rd_wait   <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= 16'h0000;
            ptr       <= 16'h0000;
            exec_q    <= 16'h0000;
            remaining <= 17'd0;
            blk_left  <= 9'd0;
            lat_cnt   <= 3'd0;
            upload_q  <= 1'b0;
        end else begin
            done     <= finish;
            err      <= reject;
            mem_rd   <= start_fetch;
            upload_q <= upload;

            if (load_byte) rd_data <= byte_nxt;

            if (arm) begin
                ptr       <= start_addr;
                exec_q    <= exec_addr;
                remaining <= n_bytes;
                file_size <= size_calc;
                busy      <= 1'b1;
            end else if (finish || abort) begin
                busy <= 1'b0;
            end

            if (start_fetch) begin
                rd_wait  <= 1'b1;
                mem_addr <= ptr;
                lat_cnt  <= 3'd0;
            end else begin
                if (capture || abort) rd_wait <= 1'b0;
                if (state == FETCH)   lat_cnt <= lat_cnt + 3'd1;
            end

            if (load_rec)
                blk_left <= (remaining > BLK_SIZE17) ? 9'(BLK_SIZE) : remaining[8:0];

            if (capture) begin
                remaining <= remaining - 17'd1;
                blk_left  <= blk_left - 9'd1;
                // Saturate so a range ending at 0xFFFF never wraps to 0x0000.
                if (ptr != 16'hFFFF) ptr <= ptr + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_cmd_saver.sv
// Directed bench for cmd_saver: two instances (256-byte and 16-byte records)
// share stimulus; each has its own RAM model with MEM_LAT read latency.
module tb_cmd_saver;

    localparam int MEM_LAT = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        save_req;
    logic [15:0] start_addr, end_addr, exec_addr;
    logic        upload;
    logic        rd_req;

    logic [23:0] file_size0, file_size1;
    logic        busy0, busy1, done0, done1, err0, err1;
    logic [7:0]  rd_data0, rd_data1;
    logic        rd_wait0, rd_wait1, mem_rd0, mem_rd1;
    logic [15:0] mem_addr0, mem_addr1;
    logic [7:0]  mem_data0, mem_data1;

    logic [7:0]  ram [0:65535];
    logic [15:0] p0_addr [MEM_LAT];
    logic        p0_vld  [MEM_LAT];
    logic [15:0] p1_addr [MEM_LAT];
    logic        p1_vld  [MEM_LAT];

    int n_cmp = 0;
    int n_err = 0;

    logic        sel = 1'b0;
    logic [7:0]  rd_data_s;
    logic        rd_wait_s, mem_rd_s;
    logic [15:0] mem_addr_s;

    always #5 clock = ~clock;

    cmd_saver #(.MEM_LAT(MEM_LAT), .BLK_LOG2(8)) dut0 (
        .clock(clock), .reset_n(reset_n), .save_req(save_req),
        .start_addr(start_addr), .end_addr(end_addr), .exec_addr(exec_addr),
        .file_size(file_size0), .busy(busy0), .done(done0), .err(err0),
        .upload(upload), .rd_req(rd_req), .rd_data(rd_data0), .rd_wait(rd_wait0),
        .mem_rd(mem_rd0), .mem_addr(mem_addr0), .mem_data(mem_data0)
    );

    cmd_saver #(.MEM_LAT(MEM_LAT), .BLK_LOG2(4)) dut1 (
        .clock(clock), .reset_n(reset_n), .save_req(save_req),
        .start_addr(start_addr), .end_addr(end_addr), .exec_addr(exec_addr),
        .file_size(file_size1), .busy(busy1), .done(done1), .err(err1),
        .upload(upload), .rd_req(rd_req), .rd_data(rd_data1), .rd_wait(rd_wait1),
        .mem_rd(mem_rd1), .mem_addr(mem_addr1), .mem_data(mem_data1)
    );

    // RAM models: data is driven only in the single cycle MEM_LAT after mem_rd.
    always @(posedge clock) begin
        p0_vld[0]  <= mem_rd0;
        p0_addr[0] <= mem_addr0;
        p1_vld[0]  <= mem_rd1;
        p1_addr[0] <= mem_addr1;
        for (int k = 1; k < MEM_LAT; k++) begin
            p0_vld[k]  <= p0_vld[k-1];
            p0_addr[k] <= p0_addr[k-1];
            p1_vld[k]  <= p1_vld[k-1];
            p1_addr[k] <= p1_addr[k-1];
        end
    end

    assign mem_data0 = p0_vld[MEM_LAT-1] ? ram[p0_addr[MEM_LAT-1]] : 8'hEE;
    assign mem_data1 = p1_vld[MEM_LAT-1] ? ram[p1_addr[MEM_LAT-1]] : 8'hEE;

    assign rd_data_s  = sel ? rd_data1  : rd_data0;
    assign rd_wait_s  = sel ? rd_wait1  : rd_wait0;
    assign mem_rd_s   = sel ? mem_rd1   : mem_rd0;
    assign mem_addr_s = sel ? mem_addr1 : mem_addr0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue one rd_req at a negedge; return at the negedge the byte is valid.
    task automatic get_byte(output logic [7:0] b, output int waits, output logic [15:0] addr);
        rd_req = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rd_req = 1'b0;
        waits  = 0;
        addr   = mem_rd_s ? mem_addr_s : 16'h0000;
        while (rd_wait_s && waits < 20) begin
            waits++;
            @(negedge clock);
        end
        b = rd_data_s;
    endtask

    task automatic expect_hdr(input string tag, input logic [7:0] exp);
        logic [7:0]  b;
        int          w;
        logic [15:0] a;
        get_byte(b, w, a);
        check(tag, 32'(b), 32'(exp));
        check({tag, " wait"}, 32'(w), 32'd0);
    endtask

    task automatic expect_data(input string tag, input logic [15:0] exp_addr);
        logic [7:0]  b;
        int          w;
        logic [15:0] a;
        get_byte(b, w, a);
        check(tag, 32'(b), 32'(ram[exp_addr]));
        check({tag, " addr"}, 32'(a), 32'(exp_addr));
        check({tag, " wait"}, 32'(w), 32'(MEM_LAT + 1));
    endtask

    task automatic do_save(input logic [15:0] s, input logic [15:0] e, input logic [15:0] x);
        start_addr = s;
        end_addr   = e;
        exec_addr  = x;
        save_req   = 1'b1;
        @(negedge clock);
        save_req   = 1'b0;
    endtask

    task automatic abort_pulse();
        upload = 1'b0;
        @(negedge clock);
        upload = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b;
        int          w;
        logic [15:0] a;
        logic        done_seen;

        for (int i = 0; i < 65536; i++)
            ram[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
        ram[16'h5200] = 8'hA5;

        reset_n    = 1'b0;
        save_req   = 1'b0;
        start_addr = 16'h0000;
        end_addr   = 16'h0000;
        exec_addr  = 16'h0000;
        upload     = 1'b1;
        rd_req     = 1'b0;
        repeat (3) @(negedge clock);

        // Reset state
        check("rst busy",      32'(busy0),      32'd0);
        check("rst done",      32'(done0),      32'd0);
        check("rst err",       32'(err0),       32'd0);
        check("rst rd_data",   32'(rd_data0),   32'd0);
        check("rst rd_wait",   32'(rd_wait0),   32'd0);
        check("rst mem_rd",    32'(mem_rd0),    32'd0);
        check("rst mem_addr",  32'(mem_addr0),  32'd0);
        check("rst file_size", 32'(file_size0), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Single byte at 0x5200
        do_save(16'h5200, 16'h5200, 16'h5200);
        check("t1 busy", 32'(busy0), 32'd1);
        check("t1 size", 32'(file_size0), 32'd9);
        expect_hdr("t1 type", 8'h01);
        expect_hdr("t1 len",  8'h03);
        expect_hdr("t1 alo",  8'h00);
        expect_hdr("t1 ahi",  8'h52);
        get_byte(b, w, a);
        check("t1 data",      32'(b), 32'hA5);
        check("t1 data wait", 32'(w), 32'(MEM_LAT + 1));
        check("t1 data addr", 32'(a), 32'h5200);
        expect_hdr("t1 xtype", 8'h02);
        expect_hdr("t1 xlen",  8'h02);
        expect_hdr("t1 xlo",   8'h00);
        check("t1 done early", 32'(done0), 32'd0);
        expect_hdr("t1 xhi",   8'h52);
        check("t1 done", 32'(done0), 32'd1);
        check("t1 busy end", 32'(busy0), 32'd0);
        @(negedge clock);
        check("t1 done pulse", 32'(done0), 32'd0);

        // One full 256-byte record
        abort_pulse();
        do_save(16'h6000, 16'h60FF, 16'h6000);
        check("t2 size", 32'(file_size0), 32'd264);
        expect_hdr("t2 type", 8'h01);
        expect_hdr("t2 len",  8'h02);
        expect_hdr("t2 alo",  8'h00);
        expect_hdr("t2 ahi",  8'h60);
        for (int i = 0; i < 256; i++)
            expect_data($sformatf("t2 data %0d", i), 16'h6000 + 16'(i));
        expect_hdr("t2 xtype", 8'h02);
        expect_hdr("t2 xlen",  8'h02);
        expect_hdr("t2 xlo",   8'h00);
        expect_hdr("t2 xhi",   8'h60);
        check("t2 done", 32'(done0), 32'd1);

        // 257 bytes: two records, the second carrying one byte
        abort_pulse();
        do_save(16'h6000, 16'h6100, 16'h6000);
        check("t3 size", 32'(file_size0), 32'd269);
        expect_hdr("t3 type", 8'h01);
        expect_hdr("t3 len",  8'h02);
        expect_hdr("t3 alo",  8'h00);
        expect_hdr("t3 ahi",  8'h60);
        for (int i = 0; i < 256; i++)
            expect_data($sformatf("t3 data %0d", i), 16'h6000 + 16'(i));
        expect_hdr("t3 type2", 8'h01);
        expect_hdr("t3 len2",  8'h03);
        expect_hdr("t3 alo2",  8'h00);
        expect_hdr("t3 ahi2",  8'h61);
        expect_data("t3 last", 16'h6100);
        expect_hdr("t3 xtype", 8'h02);
        expect_hdr("t3 xlen",  8'h02);
        expect_hdr("t3 xlo",   8'h00);
        expect_hdr("t3 xhi",   8'h60);
        check("t3 done", 32'(done0), 32'd1);

        // 16-byte records on the second instance
        abort_pulse();
        do_save(16'h7000, 16'h7010, 16'h7000);
        check("t4 size blk256", 32'(file_size0), 32'd25);
        check("t4 size blk16",  32'(file_size1), 32'd29);
        sel = 1'b1;
        expect_hdr("t4 type", 8'h01);
        expect_hdr("t4 len",  8'h12);
        expect_hdr("t4 alo",  8'h00);
        expect_hdr("t4 ahi",  8'h70);
        for (int i = 0; i < 16; i++)
            expect_data($sformatf("t4 data %0d", i), 16'h7000 + 16'(i));
        expect_hdr("t4 type2", 8'h01);
        expect_hdr("t4 len2",  8'h03);
        expect_hdr("t4 alo2",  8'h10);
        expect_hdr("t4 ahi2",  8'h70);
        expect_data("t4 last", 16'h7010);
        expect_hdr("t4 xtype", 8'h02);
        expect_hdr("t4 xlen",  8'h02);
        expect_hdr("t4 xlo",   8'h00);
        expect_hdr("t4 xhi",   8'h70);
        check("t4 done", 32'(done1), 32'd1);
        sel = 1'b0;

        // Full address space: size and opening bytes
        abort_pulse();
        do_save(16'h0000, 16'hFFFF, 16'h0000);
        check("t5 size blk256", 32'(file_size0), 32'h010404);
        check("t5 size blk16",  32'(file_size1), 32'h014004);
        expect_hdr("t5 type", 8'h01);
        expect_hdr("t5 len",  8'h02);
        expect_hdr("t5 alo",  8'h00);
        expect_hdr("t5 ahi",  8'h00);
        expect_data("t5 data 0", 16'h0000);
        expect_data("t5 data 1", 16'h0001);
        abort_pulse();
        check("t5 abort busy", 32'(busy0), 32'd0);

        // Top of memory: pointer must stop at 0xFFFF
        do_save(16'hFF00, 16'hFFFF, 16'h1234);
        check("t6 size", 32'(file_size0), 32'd264);
        expect_hdr("t6 type", 8'h01);
        expect_hdr("t6 len",  8'h02);
        expect_hdr("t6 alo",  8'h00);
        expect_hdr("t6 ahi",  8'hFF);
        for (int i = 0; i < 256; i++)
            expect_data($sformatf("t6 data %0d", i), 16'hFF00 + 16'(i));
        check("t6 mem_addr end", 32'(mem_addr0), 32'hFFFF);
        expect_hdr("t6 xtype", 8'h02);
        expect_hdr("t6 xlen",  8'h02);
        expect_hdr("t6 xlo",   8'h34);
        expect_hdr("t6 xhi",   8'h12);
        check("t6 done", 32'(done0), 32'd1);
        abort_pulse();

        // Rejected range, then a valid save; a save_req while busy is ignored
        do_save(16'h8000, 16'h7FFF, 16'h1111);
        check("t7 err", 32'(err0), 32'd1);
        check("t7 busy", 32'(busy0), 32'd0);
        @(negedge clock);
        check("t7 err pulse", 32'(err0), 32'd0);
        do_save(16'h5200, 16'h5200, 16'h5200);
        check("t7 busy ok", 32'(busy0), 32'd1);
        check("t7 size", 32'(file_size0), 32'd9);
        expect_hdr("t7 type", 8'h01);
        do_save(16'h6000, 16'h60FF, 16'h6000);
        check("t7 size held", 32'(file_size0), 32'd9);
        expect_hdr("t7 len", 8'h03);
        abort_pulse();

        // Host abort in the middle of a fetch
        do_save(16'h6000, 16'h60FF, 16'h6000);
        expect_hdr("t8 type", 8'h01);
        expect_hdr("t8 len",  8'h02);
        expect_hdr("t8 alo",  8'h00);
        expect_hdr("t8 ahi",  8'h60);
        for (int i = 0; i < 6; i++)
            expect_data($sformatf("t8 data %0d", i), 16'h6000 + 16'(i));
        rd_req = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rd_req = 1'b0;
        check("t8 in fetch", 32'(rd_wait0), 32'd1);
        upload = 1'b0;
        done_seen = 1'b0;
        @(negedge clock);
        check("t8 abort busy",    32'(busy0),    32'd0);
        check("t8 abort rd_wait", 32'(rd_wait0), 32'd0);
        upload = 1'b1;
        for (int i = 0; i < 8; i++) begin
            done_seen = done_seen | done0;
            @(negedge clock);
        end
        check("t8 no done", 32'(done_seen), 32'd0);
        check("t8 discarded", 32'(rd_data0), 32'(ram[16'h6005]));
        expect_hdr("t8 idle read", 8'h00);
        check("t8 idle busy", 32'(busy0), 32'd0);
        do_save(16'h6000, 16'h60FF, 16'h6000);
        expect_hdr("t8 restart type", 8'h01);
        expect_hdr("t8 restart len",  8'h02);
        abort_pulse();

        // Reset in the middle of a save
        do_save(16'h5200, 16'h5200, 16'h5200);
        expect_hdr("t9 type", 8'h01);
        expect_hdr("t9 len",  8'h03);
        reset_n = 1'b0;
        #1;
        check("t9 rst busy",    32'(busy0),      32'd0);
        check("t9 rst rd_data", 32'(rd_data0),   32'd0);
        check("t9 rst size",    32'(file_size0), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        do_save(16'h5200, 16'h5200, 16'h5200);
        expect_hdr("t9 restart type", 8'h01);
        expect_hdr("t9 restart len",  8'h03);
        expect_hdr("t9 restart alo",  8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
